// File: rtl/wb_pkg.sv
// Shared writeback definitions: source-select encoding and sequencer state enum.
// Also used by the main control and the writeback mux.
package wb_pkg;

    localparam logic [2:0] WB_ALU   = 3'b000;
    localparam logic [2:0] WB_LS    = 3'b001;
    localparam logic [2:0] WB_SHIFT = 3'b010;
    localparam logic [2:0] WB_MUX10 = 3'b011;
    localparam logic [2:0] WB_LUI   = 3'b100;
    localparam logic [2:0] WB_SEXT1 = 3'b101;
    localparam logic [2:0] WB_C227  = 3'b110;
    localparam logic [2:0] WB_RSVD  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2,
        S_ERR   = 2'd3
    } wb_state_t;

endpackage

// File: rtl/wb_sequencer.sv
// Writeback sequencer: latches one request, waits for a multicycle source, issues a one-cycle RegWrite.
// Latency: immediate sources write 1 cycle after accept; waited sources 1 cycle after done, abort after TIMEOUT wait cycles.
// Backpressure: wb_ready is high only in IDLE; the requester holds wb_req until it is accepted.
module wb_sequencer
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wb_req,
    input  logic [2:0] wb_src,
    input  logic [4:0] wb_dst,
    input  logic       mem_done,
    input  logic       shift_done,
    output logic       wb_ready,
    output logic [2:0] w_MemToReg,
    output logic [4:0] w_WriteReg,
    output logic       w_RegWrite,
    output logic       wb_done,
    output logic       wb_err
);

    wb_state_t       state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            src_done;
    logic            timed_out;

    assign accept    = (state == S_IDLE) && wb_req;
    assign timed_out = (cnt == CW'(TIMEOUT - 1));

    // Only the done signal belonging to the latched source counts.
    always_comb begin
        src_done = 1'b0;
        if (w_MemToReg == WB_LS)
            src_done = mem_done;
        else if (w_MemToReg == WB_SHIFT)
            src_done = shift_done;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            w_MemToReg <= WB_ALU;
            w_WriteReg <= 5'd0;
            cnt        <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                w_MemToReg <= wb_src;
                w_WriteReg <= wb_dst;
                cnt        <= '0;
            end else if (state == S_WAIT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (wb_req) begin
                    if (wb_src == WB_RSVD)
                        state_nxt = S_ERR;
                    else if (wb_src == WB_LS || wb_src == WB_SHIFT)
                        state_nxt = S_WAIT;
                    else
                        state_nxt = S_WRITE;
                end
            end
            // Done takes priority over a coincident timeout.
            S_WAIT: begin
                if (src_done)
                    state_nxt = S_WRITE;
                else if (timed_out)
                    state_nxt = S_ERR;
            end
            S_WRITE: state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign wb_ready   = (state == S_IDLE);
    assign wb_done    = (state == S_WRITE);
    assign wb_err     = (state == S_ERR);
    assign w_RegWrite = (state == S_WRITE) && (w_WriteReg != 5'd0);

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed self-checking bench for wb_sequencer.
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_wb_sequencer;

    logic       clk;
    logic       reset;
    logic       wb_req;
    logic [2:0] wb_src;
    logic [4:0] wb_dst;
    logic       mem_done;
    logic       shift_done;
    logic       wb_ready;
    logic [2:0] w_MemToReg;
    logic [4:0] w_WriteReg;
    logic       w_RegWrite;
    logic       wb_done;
    logic       wb_err;

    int n_checks = 0;
    int n_fail   = 0;

    wb_sequencer #(.TIMEOUT(16), .CW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_req     (wb_req),
        .wb_src     (wb_src),
        .wb_dst     (wb_dst),
        .mem_done   (mem_done),
        .shift_done (shift_done),
        .wb_ready   (wb_ready),
        .w_MemToReg (w_MemToReg),
        .w_WriteReg (w_WriteReg),
        .w_RegWrite (w_RegWrite),
        .wb_done    (wb_done),
        .wb_err     (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; wb_req = 1'b0; wb_src = 3'd0; wb_dst = 5'd0;
        mem_done = 1'b0; shift_done = 1'b0;
        #2;
        n_checks++;
        if ({wb_ready, w_MemToReg, w_WriteReg, w_RegWrite, wb_done, wb_err} !== {1'b1, 3'd0, 5'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {wb_ready, w_MemToReg, w_WriteReg, w_RegWrite, wb_done, wb_err}, {1'b1, 3'd0, 5'd0, 3'b000});
        end
        step();
        reset = 1'b0;
        step();
        chk("post_reset_ready", {7'd0, wb_ready}, 8'd1);
    endtask

    task automatic test_immediate();
        wb_req = 1'b1; wb_src = 3'b000; wb_dst = 5'd8;
        step();
        wb_req = 1'b0;
        chk("imm_regwrite", {7'd0, w_RegWrite}, 8'd1);
        chk("imm_writereg", {3'd0, w_WriteReg}, 8'd8);
        chk("imm_memtoreg", {5'd0, w_MemToReg}, 8'd0);
        chk("imm_done",     {7'd0, wb_done},    8'd1);
        chk("imm_ready_lo", {7'd0, wb_ready},   8'd0);
        step();
        chk("imm_ready_back", {7'd0, wb_ready},   8'd1);
        chk("imm_regwrite_1", {7'd0, w_RegWrite}, 8'd0);
        chk("imm_hold_dst",   {3'd0, w_WriteReg}, 8'd8);
    endtask

    task automatic test_mem_wait();
        wb_req = 1'b1; wb_src = 3'b001; wb_dst = 5'd9;
        step();
        wb_req = 1'b0;
        chk("mem_wait1_ready", {7'd0, wb_ready}, 8'd0);
        shift_done = 1'b1;
        step();
        shift_done = 1'b0;
        chk("mem_ignore_shift", {6'd0, wb_done, w_RegWrite}, 8'd0);
        step();
        mem_done = 1'b1;
        chk("mem_wait3_nodone", {7'd0, wb_done}, 8'd0);
        step();
        mem_done = 1'b0;
        chk("mem_done",     {7'd0, wb_done},    8'd1);
        chk("mem_regwrite", {7'd0, w_RegWrite}, 8'd1);
        chk("mem_memtoreg", {5'd0, w_MemToReg}, 8'd1);
        chk("mem_writereg", {3'd0, w_WriteReg}, 8'd9);
        step();
        chk("mem_idle", {7'd0, wb_ready}, 8'd1);
    endtask

    task automatic test_timeout();
        int waits = 0;
        int budget = 0;
        wb_req = 1'b1; wb_src = 3'b010; wb_dst = 5'd10;
        step();
        wb_req = 1'b0;
        while (!wb_ready && !wb_err && !wb_done && budget < 40) begin
            waits++;
            budget++;
            step();
        end
        if (budget >= 40) begin
            n_checks++; n_fail++;
            $display("FAIL timeout_bound: no exit from wait after %0d cycles", budget);
        end
        chk("to_wait_cycles", 8'(waits),            8'd16);
        chk("to_err",         {7'd0, wb_err},       8'd1);
        chk("to_no_write",    {6'd0, wb_done, w_RegWrite}, 8'd0);
        step();
        chk("to_err_single",  {7'd0, wb_err},   8'd0);
        chk("to_idle",        {7'd0, wb_ready}, 8'd1);
    endtask

    task automatic test_shift_last();
        wb_req = 1'b1; wb_src = 3'b010; wb_dst = 5'd11;
        step();
        wb_req = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("sl_still_wait", {6'd0, wb_ready, wb_err}, 8'd0);
        shift_done = 1'b1;
        step();
        shift_done = 1'b0;
        chk("sl_done",     {7'd0, wb_done},    8'd1);
        chk("sl_no_err",   {7'd0, wb_err},     8'd0);
        chk("sl_regwrite", {7'd0, w_RegWrite}, 8'd1);
        chk("sl_memtoreg", {5'd0, w_MemToReg}, 8'd2);
        step();
        chk("sl_no_err_after", {6'd0, wb_err, wb_ready}, 8'd1);
    endtask

    task automatic test_boundary();
        wb_req = 1'b1; wb_src = 3'b111; wb_dst = 5'd5;
        step();
        wb_req = 1'b0;
        chk("rsvd_err",      {7'd0, wb_err},     8'd1);
        chk("rsvd_no_write", {6'd0, wb_done, w_RegWrite}, 8'd0);
        chk("rsvd_memtoreg", {5'd0, w_MemToReg}, 8'd7);
        step();
        chk("rsvd_idle", {6'd0, wb_ready, wb_err}, 8'd2);
        wb_req = 1'b1; wb_src = 3'b110; wb_dst = 5'd0;
        step();
        wb_req = 1'b0;
        chk("zero_done",     {7'd0, wb_done},    8'd1);
        chk("zero_no_write", {7'd0, w_RegWrite}, 8'd0);
        chk("zero_memtoreg", {5'd0, w_MemToReg}, 8'd6);
        step();
    endtask

    task automatic test_reset_mid_wait();
        wb_req = 1'b1; wb_src = 3'b001; wb_dst = 5'd12;
        step();
        wb_req = 1'b0;
        step();
        chk("rmw_in_wait", {7'd0, wb_ready}, 8'd0);
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({wb_ready, w_MemToReg, w_WriteReg, w_RegWrite, wb_done, wb_err} !== {1'b1, 3'd0, 5'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL rmw_reset_outputs: got %b expected %b",
                     {wb_ready, w_MemToReg, w_WriteReg, w_RegWrite, wb_done, wb_err}, {1'b1, 3'd0, 5'd0, 3'b000});
        end
        #1;
        reset = 1'b0;
        mem_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rmw_no_write", {5'd0, w_RegWrite, wb_done, wb_err}, 8'd0);
        end
        mem_done = 1'b0;
        chk("rmw_ready", {7'd0, wb_ready}, 8'd1);
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_mem_wait();
        test_timeout();
        test_shift_last();
        test_boundary();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_sequencer.md
# wb_sequencer

Writeback sequencer for the multicycle MIPS datapath. It accepts one writeback request at a time from the main control unit and drives the register-file writeback select (`w_MemToReg`) and the destination register (`w_WriteReg`). It holds off the write until the selected source is valid, then issues a single-cycle `w_RegWrite`. It sits between the main control FSM and the writeback multiplexer / register file.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum number of cycles spent waiting for a multicycle source before the request is aborted (≥2).
- `CW`, 5: timeout counter width; must satisfy 2^CW ≥ TIMEOUT.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wb_req`  in  1  writeback request from main control.
- `wb_src`  in  3  source select, encoded as follows:
  - 000 ALUOut, 001 LS, 010 ShiftReg, 011 MUX10
  - 100 Shiftleft16, 101 SignExtend132, 110 constant 227, 111 reserved
- `wb_dst`  in  5  destination register number.
- `mem_done`  in  1  load/store unit result valid (required for source 001).
- `shift_done`  in  1  shift register result valid (required for source 010).
- `wb_ready`  out  1  sequencer can accept a request.
- `w_MemToReg`  out  3  writeback mux select.
- `w_WriteReg`  out  5  register-file write address.
- `w_RegWrite`  out  1  register-file write enable.
- `wb_done`  out  1  one-cycle pulse: request completed.
- `wb_err`  out  1  one-cycle pulse: request aborted.

## Operation
- States are IDLE, WAIT, WRITE and ERR. All outputs are Moore-decoded from the state and the latched registers.
- **IDLE:**
  - `wb_ready`=1.
  - On `wb_req`, latch `wb_src`→`w_MemToReg` and `wb_dst`→`w_WriteReg`, and clear the counter.
  - Next state on an accepted request:
    - ERR if src=111.
    - WAIT if src=001 or 010.
    - WRITE otherwise.
  - Without `wb_req`, remain in IDLE.
- **WAIT:**
  - `wb_ready`=0. The counter increments each cycle.
  - The required done signal for the latched source (`mem_done` for 001, `shift_done` for 010) moves the FSM to WRITE. The other done signal is ignored.
  - If the counter equals TIMEOUT-1 and the required done is low, go to ERR.
  - If done and timeout coincide, done wins and the FSM goes to WRITE.
- **WRITE:**
  - `wb_done`=1.
  - `w_RegWrite`=1 only if `w_WriteReg`≠0. A write to $zero is suppressed, but `wb_done` still pulses.
  - Next state is always IDLE.
- **ERR:**
  - `wb_err`=1, `w_RegWrite`=0.
  - Next state is always IDLE.
- `w_MemToReg` and `w_WriteReg` keep their latched values through WAIT/WRITE/ERR and in IDLE until the next accept, so the mux input settles before the write.
- Done inputs are sampled only in WAIT. Pulses in IDLE, WRITE or ERR are ignored.
- `wb_req` is ignored when `wb_ready`=0; the requester must hold it.

## Timing
- Reset (asynchronous, any state): state=IDLE, `w_MemToReg`=000, `w_WriteReg`=0, counter=0, `w_RegWrite`=0, `wb_done`=0, `wb_err`=0, `wb_ready`=1.
  - Reset mid-WAIT discards the request without a write or error pulse.
- Immediate sources (000, 011, 100, 101, 110): accept at edge N; WRITE during cycle N+1; `wb_ready` returns at N+2. Throughput is one request per 2 cycles.
- Waited sources: done seen high at WAIT cycle M → WRITE during M+1.
- WAIT lasts at most TIMEOUT cycles. If the source stays silent, ERR occurs in the cycle after the TIMEOUT-th WAIT cycle.
- Reserved source: accept at N → ERR during N+1 → IDLE at N+2.

## Structure
- A shared package `wb_pkg` holds:
  - The source encoding constants (`WB_ALU`, `WB_LS`, `WB_SHIFT`, `WB_MUX10`, `WB_LUI`, `WB_SEXT1`, `WB_C227`, `WB_RSVD`), reused by the main control and the writeback mux.
  - The state enum.
- The block is a single module with no sub-module. The timeout counter stays inline.

## Test plan
1. After reset: `wb_ready`=1, all other outputs 0, select 000.
2. Request src=000, dst=8 at cycle 1:
   - cycle 2: `w_RegWrite`=1, `w_WriteReg`=8, `w_MemToReg`=000, `wb_done`=1.
   - cycle 3: `wb_ready`=1.
3. Request src=001, dst=9; `mem_done` pulsed on the 3rd WAIT cycle → WRITE one cycle later with select 001. A `shift_done` pulse during the wait is ignored.
4. Request src=010 with TIMEOUT=16 and `shift_done` never asserted → exactly 16 WAIT cycles, then a single `wb_err` pulse with no `w_RegWrite`. A second run with `shift_done` on the 16th WAIT cycle → WRITE, no error.
5. Boundary requests:
   - src=111 → `wb_err` on the next cycle, no write.
   - src=110, dst=0 → `wb_done`=1 with `w_RegWrite`=0.
6. Assert `reset` mid-WAIT for src=001 → outputs return to reset values immediately. A later `mem_done` produces no write.
